// File: rtl/bcd_conv_sched_pkg.sv
// Shared alarm-clock constants: requester count, FSM encodings and BCD helpers.
package bcd_conv_sched_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A packed-BCD digit is only legal in the range 0..9.
  function automatic logic nibble_bad(input logic [3:0] nib);
    return (nib > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Request/grant/result bundle shared by the two requesters and the scheduler.
interface bcd_conv_sched_if;
  import bcd_conv_sched_pkg::*;

  logic [NREQ-1:0] req;
  logic [7:0]      bcd0;
  logic [7:0]      bcd1;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [6:0]      bin_out;
  logic            err;

  modport master (output req, bcd0, bcd1, input gnt, done, bin_out, err);
  modport slave  (input req, bcd0, bcd1, output gnt, done, bin_out, err);

endinterface

// File: rtl/bcd_conv_sched_bcd_to_bin.sv
// Two-digit packed BCD to binary converter. Output is meaningful only for
// legal digits; the caller flags illegal nibbles separately.
module bcd_conv_sched_bcd_to_bin (
  input  logic [7:0] bcd,
  output logic [6:0] bin
);

  assign bin = {3'd0, bcd[7:4]} * 7'd10 + {3'd0, bcd[3:0]};

endmodule

// File: rtl/bcd_conv_sched.sv
// Time-shares one BCD-to-binary converter between two requesters with
// round-robin arbitration.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no operation; arbitrate pending requests, latch operand
//   CONV    | converter driven from bcd_q; result captured at next edge
//   DONE    | done = gnt for one cycle; gnt cleared at next edge
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int MAX0 = 23,
  parameter int MAX1 = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_conv_sched_if.slave  bus
);

  localparam logic [6:0] MAX0_B = 7'(MAX0);
  localparam logic [6:0] MAX1_B = 7'(MAX1);

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [6:0]      bin_q;
  logic            err_q;
  logic [7:0]      bcd_q;
  logic            last_q;

  logic            win;
  logic [6:0]      bin_c;
  logic [6:0]      max_c;
  logic            err_c;

  bcd_conv_sched_bcd_to_bin u_conv (
    .bcd (bcd_q),
    .bin (bin_c)
  );

  // Round-robin pick: lone request wins, a tie goes to whoever was not last.
  always_comb begin
    win = 1'b0;
    if (bus.req == 2'b11)
      win = ~last_q;
    else if (bus.req[1] && !bus.req[0])
      win = 1'b1;
  end

  // Range/digit check against the limit of the requester currently granted.
  always_comb begin
    max_c = gnt_q[1] ? MAX1_B : MAX0_B;
    err_c = nibble_bad(bcd_q[7:4]) || nibble_bad(bcd_q[3:0]) || (bin_c > max_c);
  end

  // Scheduler FSM with registered grant, completion and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      bcd_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= '0;
          if (bus.req != '0) begin
            gnt_q   <= win ? 2'b10 : 2'b01;
            bcd_q   <= win ? bus.bcd1 : bus.bcd0;
            last_q  <= win;
            state_q <= ST_CONV;
          end else begin
            gnt_q <= '0;
          end
        end
        ST_CONV: begin
          bin_q   <= err_c ? 7'd0 : bin_c;
          err_q   <= err_c;
          done_q  <= gnt_q;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed self-checking bench for the BCD conversion scheduler.
module tb_bcd_conv_sched;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_conv_sched_if bus ();

  bcd_conv_sched #(.MAX0(23), .MAX1(59)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at a falling edge and step past the accepting edge.
  task automatic issue(input logic [1:0] r, input logic [7:0] b0, input logic [7:0] b1);
    bus.req  = r;
    bus.bcd0 = b0;
    bus.bcd1 = b1;
    @(negedge clk);
  endtask

  // Step one cycle at a time until done is seen or the budget runs out.
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done !== 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = 2'b00;
    bus.bcd0 = 8'h00;
    bus.bcd1 = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", bus.gnt); end
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", bus.done); end
    checks++; if (bus.bin_out !== 7'd0) begin errors++; $display("FAIL reset_bin got %0d want 0", bus.bin_out); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single conversion on requester 0 with exact latency checks.
  task automatic test_single_r0();
    issue(2'b01, 8'h15, 8'h00);
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL r0_gnt got %b want 01", bus.gnt); end
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL r0_early_done got %b want 00", bus.done); end
    bus.req = 2'b00;
    @(negedge clk);
    checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL r0_done got %b want 01", bus.done); end
    checks++; if (bus.bin_out !== 7'd15) begin errors++; $display("FAIL r0_bin got %0d want 15", bus.bin_out); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL r0_err got %b want 0", bus.err); end
    @(negedge clk);
    checks++; if (bus.done !== 2'b00 || bus.gnt !== 2'b00) begin errors++; $display("FAIL r0_release got done=%b gnt=%b want 00/00", bus.done, bus.gnt); end
  endtask

  // Requester 1 against its 59 limit: just over and exactly at the limit.
  task automatic test_r1_range();
    logic [7:0] vec [2]  = '{8'h60, 8'h59};
    logic [6:0] ebin [2] = '{7'd0, 7'd59};
    logic       eerr [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      issue(2'b10, 8'h00, vec[k]);
      checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL r1_gnt[%0d] got %b want 10", k, bus.gnt); end
      bus.req = 2'b00;
      @(negedge clk);
      checks++; if (bus.done !== 2'b10) begin errors++; $display("FAIL r1_done[%0d] got %b want 10", k, bus.done); end
      checks++; if (bus.bin_out !== ebin[k]) begin errors++; $display("FAIL r1_bin[%0d] got %0d want %0d", k, bus.bin_out, ebin[k]); end
      checks++; if (bus.err !== eerr[k]) begin errors++; $display("FAIL r1_err[%0d] got %b want %b", k, bus.err, eerr[k]); end
      @(negedge clk);
    end
  endtask

  // Requester 0: bad digits, over the 23 limit, at the limit and zero.
  task automatic test_r0_errors();
    logic [7:0] vec [5]  = '{8'h0F, 8'hA0, 8'h24, 8'h23, 8'h00};
    logic [6:0] ebin [5] = '{7'd0, 7'd0, 7'd0, 7'd23, 7'd0};
    logic       eerr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      issue(2'b01, vec[k], 8'h00);
      bus.req = 2'b00;
      @(negedge clk);
      checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL r0e_done[%0d] got %b want 01", k, bus.done); end
      checks++; if (bus.bin_out !== ebin[k]) begin errors++; $display("FAIL r0e_bin[%0d] got %0d want %0d", k, bus.bin_out, ebin[k]); end
      checks++; if (bus.err !== eerr[k]) begin errors++; $display("FAIL r0e_err[%0d] got %b want %b", k, bus.err, eerr[k]); end
      @(negedge clk);
    end
  endtask

  // Both requesting from reset: grants alternate 0, 1, 0.
  task automatic test_back_to_back();
    logic [1:0] edone [3] = '{2'b01, 2'b10, 2'b01};
    logic [6:0] ebin [3]  = '{7'd12, 7'd34, 7'd12};
    bit seen;
    rst_n    = 1'b0;
    bus.req  = 2'b11;
    bus.bcd0 = 8'h12;
    bus.bcd1 = 8'h34;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL b2b_reset_gnt got %b want 00", bus.gnt); end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL b2b_timeout[%0d] got no done want %b", k, edone[k]);
      end else begin
        if (bus.done !== edone[k]) begin errors++; $display("FAIL b2b_done[%0d] got %b want %b", k, bus.done, edone[k]); end
        checks++;
        if (bus.bin_out !== ebin[k]) begin errors++; $display("FAIL b2b_bin[%0d] got %0d want %0d", k, bus.bin_out, ebin[k]); end
      end
    end
    bus.req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  // Reset during CONV abandons the op and restores the tie pointer.
  task automatic test_reset_abort();
    issue(2'b01, 8'h15, 8'h00);
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL abort_gnt got %b want 01", bus.gnt); end
    rst_n   = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL abort_done got %b want 00", bus.done); end
    checks++; if (bus.gnt !== 2'b00 || bus.bin_out !== 7'd0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL abort_outs got gnt=%b bin=%0d err=%b want 00/0/0", bus.gnt, bus.bin_out, bus.err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL abort_late_done got %b want 00", bus.done); end
    issue(2'b11, 8'h01, 8'h02);
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL abort_tie_gnt got %b want 01", bus.gnt); end
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  // Operand and request change after acceptance do not disturb the result.
  task automatic test_drop_operand();
    issue(2'b01, 8'h42, 8'h00);
    bus.req  = 2'b00;
    bus.bcd0 = 8'h99;
    @(negedge clk);
    checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL drop_done got %b want 01", bus.done); end
    checks++; if (bus.bin_out !== 7'd0 || bus.err !== 1'b1) begin
      errors++; $display("FAIL drop_result got bin=%0d err=%b want 0/1", bus.bin_out, bus.err);
    end
    @(negedge clk);
    issue(2'b01, 8'h21, 8'h00);
    bus.req  = 2'b10;
    bus.bcd0 = 8'h99;
    @(negedge clk);
    checks++; if (bus.done !== 2'b01 || bus.bin_out !== 7'd21) begin
      errors++; $display("FAIL drop_ok got done=%b bin=%0d want 01/21", bus.done, bus.bin_out);
    end
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_r0();
    test_r1_range();
    test_r0_errors();
    test_back_to_back();
    test_reset_abort();
    test_drop_operand();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter MAX0, default 23, inclusive upper limit for requester 0 (hours field).
REQ-002 Parameter MAX1, default 59, inclusive upper limit for requester 1 (minutes field).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req  input  2  per-requester conversion request; bit n = requester n.
REQ-007 bcd0  input  8  requester 0 two-digit packed BCD operand (tens [7:4], ones [3:0]).
REQ-008 bcd1  input  8  requester 1 two-digit packed BCD operand.
REQ-009 gnt  output  2  one-hot registered grant; zero when idle.
REQ-010 done  output  2  one-cycle completion pulse to granted requester.
REQ-011 bin_out  output  7  registered binary result; valid while done is nonzero.
REQ-012 err  output  1  registered error flag; valid while done is nonzero.

Function
REQ-013 The block SHALL time-share one BCD_to_bin converter between two requesters through FSM states IDLE, CONV, DONE.
REQ-014 IDLE: if any req bit is high at an edge, latch the winner into gnt, copy its operand into bcd_q (drives the converter), go to CONV; otherwise stay in IDLE with gnt=0.
REQ-015 CONV: at the next edge, capture result into bin_out and err, go to DONE.
REQ-016 DONE: done = gnt for exactly this cycle; at the next edge clear gnt, return to IDLE.
REQ-017 Latency: accepting edge E, done high in the cycle after edge E+1; next grant no earlier than edge E+2.
REQ-018 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the requester not granted last wins; the last-granted pointer resets to 1 so requester 0 wins the first tie.
REQ-019 err SHALL be 1 if either nibble of bcd_q exceeds 9, or if the converted value exceeds MAX of the granted requester.
REQ-020 When err is 1, bin_out SHALL be 0; otherwise bin_out = 10*tens + ones.
REQ-021 Operands are sampled only at the accepting edge; later changes to bcd0/bcd1 do not affect the result in flight.
REQ-022 A req dropped after acceptance SHALL NOT abort the operation; done still pulses.
REQ-023 A req still high in IDLE after its done is a new request and is arbitrated normally.
REQ-024 The non-granted requester's req is ignored until the block returns to IDLE.

Reset
REQ-025 With rst_n low at an edge: state=IDLE, gnt=0, done=0, bin_out=0, err=0, bcd_q=0, pointer=1.
REQ-026 Reset in CONV or DONE SHALL abandon the operation with no done pulse.

Structure
REQ-027 FSM state encodings and the requester count SHALL live in the shared alarm-clock constants header/package.
REQ-028 The only sub-module SHALL be the existing BCD_to_bin converter (BCD 8-bit in, bin 7-bit out), instantiated once.

Verification
REQ-029 req=01, bcd0=0x15 -> gnt=01 after accepting edge; done=01, bin_out=15, err=0 one cycle later.
REQ-030 req=10, bcd1=0x60 -> done=10, err=1, bin_out=0; bcd1=0x59 -> bin_out=59, err=0.
REQ-031 req=01, bcd0=0x0F -> err=1 (ones nibble >9); bcd0=0x24 with MAX0=23 -> err=1, bin_out=0.
REQ-032 req=11 held from reset, bcd0=0x12, bcd1=0x34 -> done=01 (bin 12), then done=10 (bin 34), then done=01 again.
REQ-033 req=01 accepted, rst_n low during CONV -> no done pulse, all outputs 0, next tie grants requester 0.
REQ-034 req=01 accepted then dropped, bcd0 changed to 0x99 in CONV -> done=01 with original result.
